// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, functs,
// FSM states, ALU operation codes, datapath mux selects, instruction classes.
package mips_ctrl_pkg;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function field of interest
  localparam logic [5:0] FUNCT_JR = 6'h08;

  // ALU operation codes; anything above FUNCT is an I-type opcode passthrough
  localparam logic [5:0] ALUOP_ADD   = 6'd0;
  localparam logic [5:0] ALUOP_SUB   = 6'd1;
  localparam logic [5:0] ALUOP_FUNCT = 6'd2;

  // pc_src selects
  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_RS     = 2'd3;

  // alu_src_b selects
  localparam logic [1:0] ALUB_RT     = 2'd0;
  localparam logic [1:0] ALUB_FOUR   = 2'd1;
  localparam logic [1:0] ALUB_IMM    = 2'd2;
  localparam logic [1:0] ALUB_IMM_SH = 2'd3;

  // reg_dst selects
  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  // mem_to_reg selects
  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  // FSM state encodings (visible on state_o)
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_ADDR   = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWR  = 4'd4,
    S_MEMWB  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ERR    = 4'd10
  } state_t;

  // Instruction classes produced by the opcode decoder
  typedef enum logic [3:0] {
    CLS_ILLEGAL = 4'd0,
    CLS_RALU    = 4'd1,
    CLS_IALU    = 4'd2,
    CLS_LOAD    = 4'd3,
    CLS_STORE   = 4'd4,
    CLS_BRANCH  = 4'd5,
    CLS_J       = 4'd6,
    CLS_JAL     = 4'd7,
    CLS_JR      = 4'd8
  } instr_class_t;

  // States that drive the memory port and are subject to the wait-state timeout
  function automatic logic is_access_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_opcode_decode.sv
// Combinational opcode/funct decoder: classifies the instruction held in IR
// and supplies the ALU operation used by EXEC.
module mc_opcode_decode
  import mips_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 6,
  parameter bit LINK_EN = 1'b1
) (
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  output instr_class_t       iclass,
  output logic [ALUOP_W-1:0] alu_op
);

  // Map opcode/funct to an instruction class and ALU operation
  always_comb begin
    iclass = CLS_ILLEGAL;
    alu_op = ALUOP_W'(opcode);
    case (opcode)
      OP_RTYPE: begin
        iclass = (funct == FUNCT_JR) ? CLS_JR : CLS_RALU;
        alu_op = ALUOP_W'(ALUOP_FUNCT);
      end
      OP_ADDI: begin
        iclass = CLS_IALU;
        alu_op = ALUOP_W'(ALUOP_ADD);
      end
      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_LUI: begin
        iclass = CLS_IALU;
        alu_op = ALUOP_W'(opcode);
      end
      OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: begin
        iclass = CLS_LOAD;
        alu_op = ALUOP_W'(ALUOP_ADD);
      end
      OP_SW, OP_SH, OP_SB: begin
        iclass = CLS_STORE;
        alu_op = ALUOP_W'(ALUOP_ADD);
      end
      OP_BEQ, OP_BNE: begin
        iclass = CLS_BRANCH;
        alu_op = ALUOP_W'(ALUOP_SUB);
      end
      OP_J: begin
        iclass = CLS_J;
        alu_op = ALUOP_W'(ALUOP_ADD);
      end
      OP_JAL: begin
        // Without link support JAL would corrupt $ra handling, so reject it
        iclass = LINK_EN ? CLS_JAL : CLS_ILLEGAL;
        alu_op = ALUOP_W'(ALUOP_ADD);
      end
      default: begin
        iclass = CLS_ILLEGAL;
        alu_op = ALUOP_W'(ALUOP_ADD);
      end
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, handles
// the memory req/ready handshake with a wait-state timeout, and drives the
// datapath strobes and mux selects.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int ALUOP_W     = 6,
  parameter int MEM_TIMEOUT = 16,
  parameter bit LINK_EN     = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               alu_zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               iord,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               branch_ne,
  output logic [1:0]         pc_src,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               reg_write,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               illegal_op,
  output logic               timeout_err,
  output logic [3:0]         state_o
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               timeout_err_q, timeout_err_d;
  logic               timed_out_s;
  instr_class_t       iclass_s;
  logic [ALUOP_W-1:0] dec_alu_op_s;

  // The branch decision is taken in the datapath from alu_zero and branch_ne;
  // the port is kept so the control unit drops into the existing interface.
  logic unused_alu_zero_s;
  assign unused_alu_zero_s = alu_zero;

  mc_opcode_decode #(
    .ALUOP_W (ALUOP_W),
    .LINK_EN (LINK_EN)
  ) u_decode (
    .opcode (opcode),
    .funct  (funct),
    .iclass (iclass_s),
    .alu_op (dec_alu_op_s)
  );

  // Memory wait budget exhausted and the access still not acknowledged
  assign timed_out_s = (wait_cnt_q == CNT_MAX) && !mem_ready;

  // State, wait counter and sticky timeout flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_FETCH;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state, wait counter and timeout flag logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)        state_d = S_DECODE;
        else if (timed_out_s) state_d = S_ERR;
        else                  state_d = S_FETCH;
      end
      S_DECODE: begin
        case (iclass_s)
          CLS_RALU, CLS_IALU:      state_d = S_EXEC;
          CLS_LOAD, CLS_STORE:     state_d = S_ADDR;
          CLS_BRANCH:              state_d = S_BRANCH;
          CLS_J, CLS_JAL, CLS_JR:  state_d = S_JUMP;
          default:                 state_d = S_FETCH;
        endcase
      end
      S_ADDR:   state_d = (iclass_s == CLS_LOAD) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (mem_ready)        state_d = S_MEMWB;
        else if (timed_out_s) state_d = S_ERR;
        else                  state_d = S_MEMRD;
      end
      S_MEMWR: begin
        if (mem_ready)        state_d = S_FETCH;
        else if (timed_out_s) state_d = S_ERR;
        else                  state_d = S_MEMWR;
      end
      S_EXEC:   state_d = S_ALUWB;
      S_MEMWB,
      S_ALUWB,
      S_BRANCH,
      S_JUMP:   state_d = S_FETCH;
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_FETCH;
    endcase

    // Counter only runs while an access waits; any acknowledge or leaving the
    // access states returns it to zero, so each access starts from a clean count.
    if (is_access_state(state_q) && !mem_ready) begin
      wait_cnt_d = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
    end else begin
      wait_cnt_d = '0;
    end

    timeout_err_d = timeout_err_q | (state_d == S_ERR);
  end

  // Moore outputs per state; FETCH strobes gated by mem_ready; all held low in reset
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_src        = PC_SRC_ALU;
    alu_src_a     = 1'b0;
    alu_src_b     = ALUB_RT;
    alu_op        = ALUOP_W'(ALUOP_ADD);
    reg_write     = 1'b0;
    reg_dst       = REGDST_RT;
    mem_to_reg    = M2R_ALUOUT;
    illegal_op    = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = ALUB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
          pc_src    = PC_SRC_ALU;
        end
        S_DECODE: begin
          alu_src_b  = ALUB_IMM_SH;
          illegal_op = (iclass_s == CLS_ILLEGAL);
        end
        S_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = ALUB_IMM;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        S_MEMWR: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          reg_dst    = REGDST_RT;
          mem_to_reg = M2R_MDR;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = (iclass_s == CLS_RALU) ? ALUB_RT : ALUB_IMM;
          alu_op    = dec_alu_op_s;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          reg_dst   = (iclass_s == CLS_RALU) ? REGDST_RD : REGDST_RT;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_src_b     = ALUB_RT;
          alu_op        = ALUOP_W'(ALUOP_SUB);
          pc_write_cond = 1'b1;
          pc_src        = PC_SRC_ALUOUT;
          branch_ne     = (opcode == OP_BNE);
        end
        S_JUMP: begin
          pc_write = 1'b1;
          case (iclass_s)
            CLS_JR:  pc_src = PC_SRC_RS;
            CLS_JAL: begin
              pc_src     = PC_SRC_JUMP;
              reg_write  = 1'b1;
              reg_dst    = REGDST_RA;
              mem_to_reg = M2R_PC;
            end
            default: pc_src = PC_SRC_JUMP;
          endcase
        end
        default: begin
          // ERR and unused encodings: every strobe stays low
          mem_req = 1'b0;
        end
      endcase
    end else begin
      mem_req = 1'b0;
    end
  end

  assign timeout_err = timeout_err_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed self-checking bench for the multicycle MIPS control unit.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       alu_zero;
  logic       mem_ready;

  logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, branch_ne;
  logic [1:0] pc_src, alu_src_b, reg_dst, mem_to_reg;
  logic       alu_src_a, reg_write, illegal_op, timeout_err;
  logic [5:0] alu_op;
  logic [3:0] state_o;

  // Second instance without link support; only state/illegal/reg_write are checked
  logic       nl_reg_write, nl_illegal_op;
  logic [3:0] nl_state_o;
  logic       unused_nl_mem_req, unused_nl_mem_we, unused_nl_iord, unused_nl_ir_write;
  logic       unused_nl_pc_write, unused_nl_pc_write_cond, unused_nl_branch_ne;
  logic [1:0] unused_nl_pc_src, unused_nl_alu_src_b, unused_nl_reg_dst, unused_nl_mem_to_reg;
  logic       unused_nl_alu_src_a, unused_nl_timeout_err;
  logic [5:0] unused_nl_alu_op;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;
  int cnt;

  mips_multicycle_control #(.ALUOP_W(6), .MEM_TIMEOUT(4), .LINK_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .branch_ne(branch_ne), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .illegal_op(illegal_op),
    .timeout_err(timeout_err), .state_o(state_o)
  );

  mips_multicycle_control #(.ALUOP_W(6), .MEM_TIMEOUT(4), .LINK_EN(1'b0)) dut_nl (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .mem_req(unused_nl_mem_req), .mem_we(unused_nl_mem_we),
    .iord(unused_nl_iord), .ir_write(unused_nl_ir_write),
    .pc_write(unused_nl_pc_write), .pc_write_cond(unused_nl_pc_write_cond),
    .branch_ne(unused_nl_branch_ne), .pc_src(unused_nl_pc_src),
    .alu_src_a(unused_nl_alu_src_a), .alu_src_b(unused_nl_alu_src_b),
    .alu_op(unused_nl_alu_op), .reg_write(nl_reg_write),
    .reg_dst(unused_nl_reg_dst), .mem_to_reg(unused_nl_mem_to_reg),
    .illegal_op(nl_illegal_op), .timeout_err(unused_nl_timeout_err),
    .state_o(nl_state_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; land 2 time units after the rising edge
  task automatic tick();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic set_ready(input logic r);
    mem_ready = r;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; opcode = 6'h00; funct = 6'h00; alu_zero = 1'b0; mem_ready = 1'b0;
    tick(); tick();
    #1;
    check_eq("rst_state", state_o, 4'd0);
    check_eq("rst_mem_req", mem_req, 1'b0);
    check_eq("rst_timeout_err", timeout_err, 1'b0);
    check_eq("rst_strobes", {ir_write, pc_write, reg_write, illegal_op}, 4'b0000);
    rst = 1'b0;

    // ADD, zero wait: 0 -> 1 -> 6 -> 7 -> 0
    opcode = 6'h00; funct = 6'h20; cyc = 0;
    set_ready(1'b1);
    check_eq("add_fetch", {state_o, mem_req, iord, ir_write, pc_write, alu_src_b}, {4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1});
    tick(); check_eq("add_decode", {state_o, alu_src_b}, {4'd1, 2'd3});
    tick(); check_eq("add_exec", {state_o, alu_src_a, alu_src_b, alu_op}, {4'd6, 1'b1, 2'd0, 6'd2});
    tick(); check_eq("add_aluwb", {state_o, reg_write, reg_dst, mem_to_reg}, {4'd7, 1'b1, 2'd1, 2'd0});
    tick(); check_eq("add_done", state_o, 4'd0);
    check_eq("add_cycles", cyc, 4);

    // ADDI: I-type writes rt, ALU op ADD
    opcode = 6'h08;
    tick(); tick();
    check_eq("addi_exec", {state_o, alu_src_b, alu_op}, {4'd6, 2'd2, 6'd0});
    tick(); check_eq("addi_aluwb", {state_o, reg_write, reg_dst}, {4'd7, 1'b1, 2'd0});
    tick();

    // ORI: opcode passed through as the ALU op
    opcode = 6'h0D;
    tick(); tick();
    check_eq("ori_exec_aluop", alu_op, 6'h0D);
    tick(); tick();

    // LW with 3 wait cycles on both accesses: 4 + 1 + 1 + 4 + 1 = 11 cycles
    opcode = 6'h23; cyc = 0; cnt = 0;
    for (int i = 0; i < 4; i++) begin
      set_ready(i == 3);
      if (state_o == 4'd0 && mem_req && !iord) cnt++;
      tick();
    end
    check_eq("lw_fetch_req_cycles", cnt, 4);
    set_ready(1'b0);
    check_eq("lw_decode", state_o, 4'd1);
    tick(); check_eq("lw_addr", {state_o, alu_src_a, alu_src_b, alu_op}, {4'd2, 1'b1, 2'd2, 6'd0});
    tick(); cnt = 0;
    for (int i = 0; i < 4; i++) begin
      set_ready(i == 3);
      if (state_o == 4'd3 && mem_req && iord && !mem_we) cnt++;
      tick();
    end
    check_eq("lw_memrd_req_cycles", cnt, 4);
    set_ready(1'b0);
    check_eq("lw_memwb", {state_o, reg_write, reg_dst, mem_to_reg}, {4'd5, 1'b1, 2'd0, 2'd1});
    tick(); check_eq("lw_done", state_o, 4'd0);
    check_eq("lw_cycles", cyc, 11);

    // BNE: 0 -> 1 -> 8 -> 0
    opcode = 6'h05; cyc = 0;
    set_ready(1'b1);
    tick(); tick();
    check_eq("bne_branch", {state_o, pc_write_cond, branch_ne, pc_src, alu_op, pc_write},
             {4'd8, 1'b1, 1'b1, 2'd1, 6'd1, 1'b0});
    tick(); check_eq("bne_cycles", {state_o, cyc[3:0]}, {4'd0, 4'd3});

    // BEQ: same state but condition is alu_zero
    opcode = 6'h04;
    tick(); tick();
    check_eq("beq_branch", {state_o, pc_write_cond, branch_ne}, {4'd8, 1'b1, 1'b0});
    tick();

    // JR: R-type funct 08 goes straight to JUMP
    opcode = 6'h00; funct = 6'h08;
    tick(); tick();
    check_eq("jr_jump", {state_o, pc_write, pc_src, reg_write}, {4'd9, 1'b1, 2'd3, 1'b0});
    tick();

    // J
    opcode = 6'h02;
    tick(); tick();
    check_eq("j_jump", {state_o, pc_src, reg_write}, {4'd9, 2'd2, 1'b0});
    tick();

    // JAL on both instances from a common reset
    do_reset();
    opcode = 6'h03; funct = 6'h00;
    set_ready(1'b1);
    tick();
    check_eq("jal_decode_illegal", illegal_op, 1'b0);
    check_eq("jal_nolink_illegal", nl_illegal_op, 1'b1);
    tick();
    check_eq("jal_jump", {state_o, pc_write, pc_src, reg_write, reg_dst, mem_to_reg},
             {4'd9, 1'b1, 2'd2, 1'b1, 2'd2, 2'd2});
    check_eq("jal_nolink_back", {nl_state_o, nl_illegal_op, nl_reg_write}, {4'd0, 1'b0, 1'b0});

    // Undefined opcode 3F: one-cycle illegal_op pulse then FETCH
    do_reset();
    opcode = 6'h3F;
    set_ready(1'b1);
    check_eq("ill_fetch_pulse", illegal_op, 1'b0);
    tick(); check_eq("ill_decode", {state_o, illegal_op}, {4'd1, 1'b1});
    tick(); check_eq("ill_after", {state_o, illegal_op}, {4'd0, 1'b0});

    // SW stalled in MEMWR, then reset with a simultaneous mem_ready
    opcode = 6'h2B;
    tick();
    set_ready(1'b0);
    tick(); tick();
    check_eq("sw_memwr", {state_o, mem_req, mem_we, iord}, {4'd4, 1'b1, 1'b1, 1'b1});
    tick(); check_eq("sw_memwr_hold", state_o, 4'd4);
    rst = 1'b1;
    set_ready(1'b1);
    tick();
    check_eq("sw_rst_state", state_o, 4'd0);
    check_eq("sw_rst_strobes", {mem_req, mem_we, ir_write, pc_write}, 4'b0000);
    tick();
    check_eq("rst_beats_ready", state_o, 4'd0);
    rst = 1'b0;

    // Ready arriving on the cycle the count hits MEM_TIMEOUT wins
    opcode = 6'h00; funct = 6'h20;
    for (int i = 0; i < 4; i++) begin
      set_ready(1'b0);
      tick();
    end
    set_ready(1'b1);
    check_eq("late_ready_fetch", {state_o, ir_write}, {4'd0, 1'b1});
    tick(); check_eq("late_ready_decode", {state_o, timeout_err}, {4'd1, 1'b0});
    tick(); tick(); tick();
    check_eq("late_ready_done", state_o, 4'd0);

    // Timeout: 5 FETCH cycles without ready, then ERR and sticky flag
    set_ready(1'b0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (state_o == 4'd0) cnt++;
      tick();
    end
    check_eq("to_fetch_cycles", cnt, 5);
    check_eq("to_err", {state_o, timeout_err, mem_req}, {4'd10, 1'b1, 1'b0});
    set_ready(1'b1);
    tick();
    check_eq("to_err_sticky", {state_o, timeout_err, ir_write, pc_write}, {4'd10, 1'b1, 1'b0, 1'b0});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_eq("to_rst_clear", {state_o, timeout_err}, {4'd0, 1'b0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
